fb_reader: RTL and testbench

Wishbone master that streams the framebuffer out of SDRAM, in raster order, into the display-side pixel FIFO. It issues incrementing bursts of `BURST` 32-bit words, starting a burst only when the FIFO can absorb it, and wraps to address 0 after the last pixel. It is the read-side counterpart of the test-pattern writer and shares the same `wshb_if` bus and framebuffer layout: pixel n sits at byte address 4·n.

---
 rtl/wshb_if.sv | 26 ++
 rtl/fb_reader.sv | 116 +++++++++++
 tb/tb_fb_reader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wshb_if.sv
// Wishbone B4 pipelined-burst bus shared by the framebuffer writer and reader.
// Clock and reset travel with the bus so every agent on it sees the same pair.
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic [31:0] dat_sm;

    modport master (
        input  clk, rst, ack, dat_sm,
        output cyc, stb, we, sel, adr, cti, bte
    );

    modport slave (
        input  clk, rst, cyc, stb, we, sel, adr, cti, bte,
        output ack, dat_sm
    );
endinterface

// File: rtl/fb_reader.sv
// Streams the framebuffer from SDRAM in raster order into the display pixel FIFO
// using incrementing Wishbone bursts, wrapping to pixel 0 after the last pixel.
//
// state   | meaning
// S_IDLE  | stb low; start a burst when the FIFO has room for a full burst
// S_BURST | stb high; one word per ack, last beat tagged cti=111
module fb_reader #(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int BURST = 16
) (
    wshb_if.master      wshb_ifm,
    input  logic        fifo_walmost_full,
    output logic        fifo_write,
    output logic [31:0] fifo_wdata,
    input  logic        frame_restart
);
    localparam int NPIX   = HDISP * VDISP;
    localparam int PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [PIX_W-1:0]  PIX_LAST    = PIX_W'(NPIX - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST   = BEAT_W'(BURST - 1);
    localparam logic [BEAT_W-1:0] BEAT_PENULT = BEAT_W'(BURST - 2);

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [2:0] CTI_FIRST   = (BURST == 1) ? CTI_END : CTI_INCR;

    if (BURST < 1 || (NPIX % BURST) != 0) begin : g_bad_burst
        $error("fb_reader: BURST must be >= 1 and divide HDISP*VDISP");
    end

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t            state;
    logic              stb_r;
    logic [2:0]        cti_r;
    logic [PIX_W-1:0]  pix;
    logic [PIX_W-1:0]  pix_next;
    logic [BEAT_W-1:0] beat;
    logic              restart_pend;

    assign wshb_ifm.cyc = stb_r;
    assign wshb_ifm.stb = stb_r;
    assign wshb_ifm.we  = 1'b0;
    assign wshb_ifm.sel = 4'hF;
    assign wshb_ifm.bte = 2'b00;
    assign wshb_ifm.cti = cti_r;
    assign wshb_ifm.adr = 32'({pix, 2'b00});

    always_comb begin
        pix_next = (pix == PIX_LAST) ? '0 : pix + 1'b1;
    end

    always_ff @(posedge wshb_ifm.clk) begin
        if (wshb_ifm.rst) begin
            state        <= S_IDLE;
            stb_r        <= 1'b0;
            cti_r        <= CTI_CLASSIC;
            pix          <= '0;
            beat         <= '0;
            restart_pend <= 1'b0;
            fifo_write   <= 1'b0;
            fifo_wdata   <= '0;
        end else begin
            fifo_write <= 1'b0;
            if (stb_r && wshb_ifm.ack) begin
                fifo_write <= 1'b1;
                fifo_wdata <= wshb_ifm.dat_sm;
            end

            case (state)
                S_IDLE: begin
                    // A restart wins over a start; the burst goes out next cycle from pixel 0.
                    if (frame_restart) begin
                        pix <= '0;
                    end else if (!fifo_walmost_full) begin
                        state <= S_BURST;
                        stb_r <= 1'b1;
                        beat  <= '0;
                        cti_r <= CTI_FIRST;
                    end
                end

                S_BURST: begin
                    if (wshb_ifm.ack && beat == BEAT_LAST) begin
                        state        <= S_IDLE;
                        stb_r        <= 1'b0;
                        cti_r        <= CTI_CLASSIC;
                        beat         <= '0;
                        pix          <= (restart_pend || frame_restart) ? '0 : pix_next;
                        restart_pend <= 1'b0;
                    end else begin
                        if (wshb_ifm.ack) begin
                            beat  <= beat + 1'b1;
                            pix   <= pix_next;
                            cti_r <= (beat == BEAT_PENULT) ? CTI_END : CTI_INCR;
                        end
                        // The running burst finishes on its own addresses; the restart lands at its end.
                        if (frame_restart) begin
                            restart_pend <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    stb_r <= 1'b0;
                    cti_r <= CTI_CLASSIC;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fb_reader.sv
// Directed bench for fb_reader on an 8x4 frame with 4-word bursts; the slave returns dat_sm = adr.
// A cycle-level behavioural model is compared every cycle, plus literal checks per scenario.
module tb_fb_reader;
    localparam int HDISP = 8;
    localparam int VDISP = 4;
    localparam int BURST = 4;
    localparam int NPIX  = HDISP * VDISP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_walmost_full = 1'b0;
    logic        frame_restart = 1'b0;
    logic        fifo_write;
    logic [31:0] fifo_wdata;

    int checks = 0;
    int errors = 0;
    int nwait = 0;
    int wcnt = 0;
    bit chk_en = 1'b0;

    // model state
    bit          m_stb = 1'b0;
    bit          m_fw = 1'b0;
    logic [31:0] m_wdata = 32'h0;
    int          m_pix = 0;
    int          m_beat = 0;
    bit          m_pend = 1'b0;

    // observation logs
    logic [31:0] push_log[$];
    logic [31:0] start_adr[$];
    int          start_cyc[$];
    logic [2:0]  cti_log[$];
    int          cyc_cnt = 0;
    int          burst_ends = 0;
    bit          prev_stb = 1'b0;

    always #5 clk = ~clk;

    wshb_if bus (.clk(clk), .rst(rst));

    fb_reader #(.HDISP(HDISP), .VDISP(VDISP), .BURST(BURST)) dut (
        .wshb_ifm          (bus.master),
        .fifo_walmost_full (fifo_walmost_full),
        .fifo_write        (fifo_write),
        .fifo_wdata        (fifo_wdata),
        .frame_restart     (frame_restart)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Slave response for the cycle just begun: ack after nwait wait states, data = address.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.stb) begin
            if (wcnt >= nwait) begin
                bus.ack = 1'b1;
                wcnt = 0;
            end else begin
                bus.ack = 1'b0;
                wcnt++;
            end
        end else begin
            bus.ack = 1'b0;
            wcnt = 0;
        end
        bus.dat_sm = bus.ack ? bus.adr : 32'hDEAD_0000;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stb", 32'(bus.stb), 32'(m_stb));
            chk("cyc", 32'(bus.cyc), 32'(m_stb));
            chk("we", 32'(bus.we), 32'h0);
            chk("sel", 32'(bus.sel), 32'hF);
            chk("bte", 32'(bus.bte), 32'h0);
            chk("fifo_write", 32'(fifo_write), 32'(m_fw));
            chk("fifo_wdata", fifo_wdata, m_wdata);
            if (m_stb) begin
                chk("adr", bus.adr, 32'(m_pix * 4));
                chk("cti", 32'(bus.cti), (m_beat == BURST - 1) ? 32'h7 : 32'h2);
            end else begin
                chk("cti_idle", 32'(bus.cti), 32'h0);
            end

            if (fifo_write) push_log.push_back(fifo_wdata);
            if (bus.stb && !prev_stb) begin
                start_adr.push_back(bus.adr);
                start_cyc.push_back(cyc_cnt);
            end
            if (!bus.stb && prev_stb) burst_ends++;
            if (bus.stb) cti_log.push_back(bus.cti);
            prev_stb = bus.stb;

            // predict the state after the coming edge
            if (rst) begin
                m_stb = 1'b0; m_fw = 1'b0; m_wdata = 32'h0;
                m_pix = 0; m_beat = 0; m_pend = 1'b0;
            end else begin
                m_fw = m_stb && bus.ack;
                if (m_fw) m_wdata = bus.dat_sm;
                if (m_stb) begin
                    if (bus.ack && m_beat == BURST - 1) begin
                        m_stb = 1'b0;
                        m_beat = 0;
                        m_pix = (m_pend || frame_restart) ? 0 : (m_pix + 1) % NPIX;
                        m_pend = 1'b0;
                    end else begin
                        if (bus.ack) begin
                            m_beat++;
                            m_pix = (m_pix + 1) % NPIX;
                        end
                        if (frame_restart) m_pend = 1'b1;
                    end
                end else if (frame_restart) begin
                    m_pix = 0;
                end else if (!fifo_walmost_full) begin
                    m_stb = 1'b1;
                    m_beat = 0;
                end
            end
            cyc_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, e0, p0, drop, pc;
        logic [31:0] base, a;
        bus.ack = 1'b0;
        bus.dat_sm = 32'h0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // zero-wait streaming over a full frame and the wrap
        for (int i = 0; i < 200 && start_adr.size() < 9; i++) tick();
        chk("p1_starts", 32'(start_adr.size()), 32'd9);
        if (start_adr.size() >= 9 && push_log.size() >= 32 && cti_log.size() >= 4) begin
            chk("p1_start0", start_adr[0], 32'h00);
            chk("p1_start1", start_adr[1], 32'h10);
            chk("p1_start7", start_adr[7], 32'h70);
            chk("p1_wrap", start_adr[8], 32'h00);
            chk("p1_gap", 32'(start_cyc[1] - start_cyc[0]), 32'd5);
            chk("p1_cti0", 32'(cti_log[0]), 32'h2);
            chk("p1_cti1", 32'(cti_log[1]), 32'h2);
            chk("p1_cti2", 32'(cti_log[2]), 32'h2);
            chk("p1_cti3", 32'(cti_log[3]), 32'h7);
            chk("p1_push3", push_log[3], 32'h0C);
            chk("p1_push31", push_log[31], 32'h7C);
            for (int i = 0; i < 32; i++) chk("p1_frame_push", push_log[i], 32'(4 * i));
        end

        // two wait states per beat
        fifo_walmost_full = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!bus.stb && !fifo_write) break;
        end
        tick();
        nwait = 2;
        p0 = push_log.size();
        e0 = burst_ends;
        fifo_walmost_full = 1'b0;
        for (int i = 0; i < 200 && burst_ends < e0 + 2; i++) tick();
        chk("p2_pushes", 32'(push_log.size() - p0), 32'd8);
        nwait = 0;

        // almost_full held in IDLE, then dropped
        fifo_walmost_full = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!bus.stb && !fifo_write) break;
        end
        s0 = start_adr.size();
        repeat (20) tick();
        chk("p3_hold_nostart", 32'(start_adr.size()), 32'(s0));
        chk("p3_hold_stb", 32'(bus.stb), 32'h0);
        fifo_walmost_full = 1'b0;
        drop = cyc_cnt;
        for (int i = 0; i < 10 && start_adr.size() <= s0; i++) tick();
        chk("p3_started", 32'(start_adr.size()), 32'(s0 + 1));
        if (start_adr.size() > s0) chk("p3_start_delay", 32'(start_cyc[s0] - drop), 32'd1);

        // almost_full raised mid-burst: burst still completes
        for (int i = 0; i < 20 && !(bus.stb && bus.adr[3:2] == 2'd1); i++) tick();
        fifo_walmost_full = 1'b1;
        base = bus.adr - 32'd4;
        e0 = burst_ends;
        for (int i = 0; i < 50 && burst_ends <= e0; i++) tick();
        if (push_log.size() >= 4) begin
            for (int k = 0; k < 4; k++)
                chk("p3_midburst_push", push_log[push_log.size() - 4 + k], base + 32'(4 * k));
        end
        s0 = start_adr.size();
        repeat (5) tick();
        chk("p3_af_nostart", 32'(start_adr.size()), 32'(s0));
        fifo_walmost_full = 1'b0;
        drop = cyc_cnt;
        for (int i = 0; i < 10 && start_adr.size() <= s0; i++) tick();
        if (start_adr.size() > s0) chk("p3_restart_delay", 32'(start_cyc[s0] - drop), 32'd1);
        else chk("p3_restart_timeout", 32'(start_adr.size()), 32'(s0 + 1));

        // frame_restart at the 2nd ack of the burst at 0x40
        for (int i = 0; i < 200 && !(bus.stb && bus.ack && bus.adr == 32'h44); i++) tick();
        chk("p4_found", bus.adr, 32'h44);
        e0 = burst_ends;
        frame_restart = 1'b1;
        tick();
        frame_restart = 1'b0;
        for (int i = 0; i < 20 && burst_ends <= e0; i++) tick();
        if (push_log.size() >= 2) begin
            chk("p4_push_48", push_log[push_log.size() - 2], 32'h48);
            chk("p4_push_4c", push_log[push_log.size() - 1], 32'h4C);
        end
        s0 = start_adr.size();
        for (int i = 0; i < 10 && start_adr.size() <= s0; i++) tick();
        if (start_adr.size() > s0) chk("p4_next_start", start_adr[s0], 32'h00);
        else chk("p4_start_timeout", 32'(start_adr.size()), 32'(s0 + 1));

        // reset mid-burst during beat 2 with ack high
        for (int i = 0; i < 100 && !(bus.stb && bus.ack && bus.adr[3:2] == 2'd2); i++) tick();
        a = bus.adr;
        chk("p5_found_beat2", 32'(a[3:2]), 32'd2);
        pc = push_log.size();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("p5_stb", 32'(bus.stb), 32'h0);
        chk("p5_fifo_write", 32'(fifo_write), 32'h0);
        chk("p5_wdata", fifo_wdata, 32'h0);
        chk("p5_pushcount", 32'(push_log.size()), 32'(pc + 1));
        if (push_log.size() > 0) chk("p5_last_push", push_log[push_log.size() - 1], a - 32'd4);
        s0 = start_adr.size();
        for (int i = 0; i < 10 && start_adr.size() <= s0; i++) tick();
        if (start_adr.size() > s0) chk("p5_next_start", start_adr[s0], 32'h00);
        else chk("p5_start_timeout", 32'(start_adr.size()), 32'(s0 + 1));

        repeat (12) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
